de2_key_debouncer: RTL and testbench



---
 rtl/de2_key_debouncer_if.sv | 21 ++
 rtl/de2_key_debouncer.sv | 108 ++++++++++
 tb/tb_de2_key_debouncer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/de2_key_debouncer_if.sv
// Signal bundle between the raw DE2 KEY pins and the conditioned key events.
// master drives the raw pins; slave is the debouncer producing clean levels and pulses.
interface de2_key_debouncer_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] KEY_n;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output KEY_n,
    input  key_state, key_press, key_release, key_repeat
  );

  modport slave (
    input  KEY_n,
    output key_state, key_press, key_release, key_repeat
  );
endinterface

// File: rtl/de2_key_debouncer.sv
// Per-key synchronizer, debouncer and auto-repeat generator for the active-low DE2 pushbuttons.
// Every channel is independent; all outputs come straight from flops.
module de2_key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               CLOCK_50,
  input  logic               RST,
  de2_key_debouncer_if.slave bus
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W  = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]   DB_ZERO    = DB_W'(0);
  localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO  = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] FIRST_TICK = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] NEXT_TICK  = HOLD_W'(REPEAT_PERIOD);
  localparam logic              REPEAT_EN  = (REPEAT_DELAY != 0);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [1:0]        sync_r;
    logic [DB_W-1:0]   db_cnt_r, db_cnt_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic              phase_r, phase_s;
    logic              state_r, state_s;
    logic              press_r, press_s;
    logic              release_r, release_s;
    logic              repeat_r, repeat_s;
    logic              sample_s;
    logic [HOLD_W-1:0] target_s;

    assign sample_s = ~sync_r[1];

    // Debounce acceptance and repeat scheduling for this key
    always_comb begin
      db_cnt_s  = db_cnt_r;
      state_s   = state_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      repeat_s  = 1'b0;
      hold_s    = hold_r;
      phase_s   = phase_r;
      target_s  = phase_r ? NEXT_TICK : FIRST_TICK;

      if (sample_s == state_r) begin
        db_cnt_s = DB_ZERO;
      end else if (db_cnt_r == DB_LAST) begin
        db_cnt_s  = DB_ZERO;
        state_s   = sample_s;
        press_s   = sample_s;
        release_s = ~sample_s;
      end else begin
        db_cnt_s = db_cnt_r + DB_ONE;
      end

      // Any flip, or a released key, restarts the repeat schedule with no pulse
      if ((state_s != state_r) || !state_r) begin
        hold_s  = HOLD_ZERO;
        phase_s = 1'b0;
      end else if (hold_r == HOLD_MAX) begin
        hold_s = hold_r;
      end else if (REPEAT_EN && ((hold_r + HOLD_ONE) == target_s)) begin
        repeat_s = 1'b1;
        hold_s   = HOLD_ZERO;
        phase_s  = 1'b1;
      end else begin
        hold_s = hold_r + HOLD_ONE;
      end
    end

    // Synchronizer, counters and registered outputs for this key
    always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
        sync_r    <= 2'b11;
        db_cnt_r  <= DB_ZERO;
        hold_r    <= HOLD_ZERO;
        phase_r   <= 1'b0;
        state_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        sync_r    <= {sync_r[0], bus.KEY_n[k]};
        db_cnt_r  <= db_cnt_s;
        hold_r    <= hold_s;
        phase_r   <= phase_s;
        state_r   <= state_s;
        press_r   <= press_s;
        release_r <= release_s;
        repeat_r  <= repeat_s;
      end
    end

    assign bus.key_state[k]   = state_r;
    assign bus.key_press[k]   = press_r;
    assign bus.key_release[k] = release_r;
    assign bus.key_repeat[k]  = repeat_r;
  end

endmodule

// File: tb/tb_de2_key_debouncer.sv
// Directed plus random bench for de2_key_debouncer; a timestamp-based model predicts every output each cycle.
module tb_de2_key_debouncer;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  de2_key_debouncer_if #(.NUM_KEYS(NK)) bus ();

  de2_key_debouncer #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: raw history since reset, accepted levels, mismatch start times, press times
  logic [NK-1:0] hist[$];
  int            edge_i;
  logic [NK-1:0] m_state, m_press, m_release, m_repeat;
  int            m_start[NK];
  int            m_press_at[NK];

  // Observed pulse statistics for directed checks
  int n_press[NK], n_release[NK], n_repeat[NK];
  int press_edge[NK], release_edge[NK], first_rep_edge[NK];

  task automatic model_reset();
    hist.delete();
    edge_i    = 0;
    m_state   = '0;
    m_press   = '0;
    m_release = '0;
    m_repeat  = '0;
    for (int k = 0; k < NK; k++) begin
      m_start[k]    = -1;
      m_press_at[k] = 0;
    end
  endtask

  // One rising edge: the debounced sample seen at edge i is the raw level present at edge i-2
  task automatic model_edge(input logic [NK-1:0] raw);
    logic [NK-1:0] old;
    logic          s;
    hist.push_back(raw);
    old       = (edge_i >= 2) ? hist[edge_i-2] : {NK{1'b1}};
    m_press   = '0;
    m_release = '0;
    m_repeat  = '0;
    for (int k = 0; k < NK; k++) begin
      s = ~old[k];
      if (s == m_state[k]) begin
        m_start[k] = -1;
      end else begin
        if (m_start[k] < 0) m_start[k] = edge_i;
        if (edge_i - m_start[k] + 1 == DB) begin
          m_state[k] = s;
          m_start[k] = -1;
          if (s) begin
            m_press[k]    = 1'b1;
            m_press_at[k] = edge_i;
          end else begin
            m_release[k] = 1'b1;
          end
        end
      end
      if (m_state[k] && !m_press[k] && (RD > 0) && (edge_i - m_press_at[k] >= RD) &&
          ((edge_i - m_press_at[k] - RD) % RP == 0))
        m_repeat[k] = 1'b1;
    end
    edge_i++;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin
      n_press[k] = 0; n_release[k] = 0; n_repeat[k] = 0;
      press_edge[k] = -1; release_edge[k] = -1; first_rep_edge[k] = -1;
    end
  endtask

  task automatic check_out(input string tag);
    tests++;
    assert (bus.key_state === m_state) else begin
      fails++; $error("FAIL %s key_state: got %b expected %b", tag, bus.key_state, m_state);
    end
    tests++;
    assert (bus.key_press === m_press) else begin
      fails++; $error("FAIL %s key_press: got %b expected %b", tag, bus.key_press, m_press);
    end
    tests++;
    assert (bus.key_release === m_release) else begin
      fails++; $error("FAIL %s key_release: got %b expected %b", tag, bus.key_release, m_release);
    end
    tests++;
    assert (bus.key_repeat === m_repeat) else begin
      fails++; $error("FAIL %s key_repeat: got %b expected %b", tag, bus.key_repeat, m_repeat);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive raw keys, let one rising edge pass, then check on the falling edge
  task automatic step(input logic [NK-1:0] kn, input string tag);
    bus.KEY_n = kn;
    @(posedge clk);
    if (!rst) model_edge(kn);
    @(negedge clk);
    check_out(tag);
    for (int k = 0; k < NK; k++) begin
      if (bus.key_press[k] === 1'b1) begin
        n_press[k]++; press_edge[k] = edge_i - 1;
      end
      if (bus.key_release[k] === 1'b1) begin
        n_release[k]++; release_edge[k] = edge_i - 1;
      end
      if (bus.key_repeat[k] === 1'b1) begin
        if (n_repeat[k] == 0) first_rep_edge[k] = edge_i - 1;
        n_repeat[k]++;
      end
    end
  endtask

  initial begin
    int            e0;
    logic [NK-1:0] kn;

    bus.KEY_n = {NK{1'b1}};
    rst       = 1'b1;
    model_reset();
    clear_counts();
    repeat (3) step(4'b1111, "reset");
    rst = 1'b0;

    // Clean press and release on key 0
    e0 = edge_i; clear_counts();
    repeat (8) step(4'b1110, "clean_press");
    expect_int("clean_press_count", n_press[0], 1);
    expect_int("clean_press_edge", press_edge[0], e0 + 5);
    expect_int("clean_no_release", n_release[0], 0);
    expect_int("clean_other_keys", n_press[1] + n_press[2] + n_press[3], 0);
    repeat (8) step(4'b1111, "clean_release");
    expect_int("clean_release_edge", release_edge[0], e0 + 13);
    expect_int("clean_no_repeat", n_repeat[0], 0);

    // Glitch rejection on key 1: 3-clock low rejected, 4-clock low accepted
    clear_counts();
    repeat (3) step(4'b1101, "glitch3");
    repeat (8) step(4'b1111, "glitch3_recover");
    expect_int("glitch3_no_press", n_press[1], 0);
    expect_int("glitch3_no_release", n_release[1], 0);
    e0 = edge_i; clear_counts();
    repeat (4) step(4'b1101, "glitch4");
    repeat (8) step(4'b1111, "glitch4_recover");
    expect_int("glitch4_press_count", n_press[1], 1);
    expect_int("glitch4_press_edge", press_edge[1], e0 + 5);
    expect_int("glitch4_release_edge", release_edge[1], e0 + 9);

    // Bounce on key 2: toggle every 2 clocks for 20 clocks, then hold low
    e0 = edge_i; clear_counts();
    for (int i = 0; i < 20; i++) step((((i / 2) % 2) == 0) ? 4'b1011 : 4'b1111, "bounce");
    repeat (8) step(4'b1011, "bounce_hold");
    expect_int("bounce_press_count", n_press[2], 1);
    expect_int("bounce_press_edge", press_edge[2], e0 + 25);
    expect_int("bounce_no_release", n_release[2], 0);
    repeat (8) step(4'b1111, "bounce_release");

    // Auto-repeat on key 3
    e0 = edge_i; clear_counts();
    repeat (30) step(4'b0111, "repeat_hold");
    expect_int("repeat_press_edge", press_edge[3], e0 + 5);
    expect_int("repeat_first_edge", first_rep_edge[3], e0 + 15);
    expect_int("repeat_count_held", n_repeat[3], 3);
    repeat (12) step(4'b1111, "repeat_release");
    expect_int("repeat_release_edge", release_edge[3], e0 + 35);
    expect_int("repeat_count_total", n_repeat[3], 4);

    // All keys pressed together, key 0 released alone
    e0 = edge_i; clear_counts();
    repeat (8) step(4'b0000, "simul");
    for (int k = 0; k < NK; k++) expect_int("simul_press_edge", press_edge[k], e0 + 5);
    repeat (8) step(4'b0001, "simul_release0");
    expect_int("simul_key0_released", n_release[0], 1);
    expect_int("simul_others_held", n_release[1] + n_release[2] + n_release[3], 0);

    // Reset while key 0 is mid-debounce and keys 1..3 are held
    repeat (3) step(4'b0000, "pre_reset");
    rst = 1'b1;
    model_reset();
    #1;
    check_out("reset_async");
    repeat (3) step(4'b0000, "in_reset");
    rst = 1'b0;
    e0 = edge_i; clear_counts();
    repeat (8) step(4'b0000, "post_reset");
    for (int k = 0; k < NK; k++) expect_int("post_reset_press_edge", press_edge[k], e0 + 5);

    // Random key activity
    kn = 4'b0000;
    repeat (800) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 7) == 0) kn[k] = ~kn[k];
      step(kn, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
